flt2int_rnd: RTL and testbench

FLT2INT_RND -- requirements
Module: flt2int_rnd

---
 rtl/flt2int_pkg.sv | 28 ++
 rtl/flt2int_round.sv | 51 +++++
 rtl/flt2int_rnd.sv | 160 ++++++++++++++++
 tb/tb_flt2int_rnd.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/flt2int_pkg.sv
// Shared types and default sizes for the float-to-integer converter.
// Holds the FSM state encoding, rounding-mode encoding and a width helper.
package flt2int_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int INT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SHIFT  = 3'd2,
    S_ROUND  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RND_TRUNC      = 2'b00,
    RND_NEAR_EVEN  = 2'b01,
    RND_NEAR_AWAY  = 2'b10,
    RND_RSVD       = 2'b11
  } rnd_mode_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flt2int_round.sv
// Combinational round / saturate / sign stage: zero latency, no flow control.
// Consumes the shifted magnitude plus guard/sticky and yields the final integer.
module flt2int_round
  import flt2int_pkg::*;
#(
  parameter int INT_W = INT_W_DEF,
  parameter int MAG_W = 16
) (
  input  logic [MAG_W-1:0] i_mag,
  input  logic             i_guard,
  input  logic             i_sticky,
  input  logic             i_sign,
  input  logic             i_sat,
  input  logic [1:0]       i_mode,
  output logic [INT_W-1:0] o_int,
  output logic             o_ovf,
  output logic             o_inexact
);

  localparam logic [MAG_W:0] W_LIM = (MAG_W+1)'(1) << (INT_W-1);

  logic             w_inc;
  logic [MAG_W:0]   w_rnd;
  logic [INT_W-1:0] w_mag_t;
  logic             w_sat;

  always_comb begin
    w_inc = 1'b0;
    case (rnd_mode_t'(i_mode))
      RND_NEAR_EVEN: w_inc = i_guard & (i_sticky | i_mag[0]);
      RND_NEAR_AWAY: w_inc = i_guard;
      default:       w_inc = 1'b0;
    endcase
  end

  assign w_rnd   = {1'b0, i_mag} + {{MAG_W{1'b0}}, w_inc};
  assign w_mag_t = w_rnd[INT_W-1:0];
  // A magnitude of exactly 2**(INT_W-1) is still representable when negative.
  assign w_sat   = i_sat | ((w_rnd >= W_LIM) & ~(i_sign & (w_rnd == W_LIM)));

  always_comb begin
    if (w_sat)
      o_int = i_sign ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    else
      o_int = i_sign ? (~w_mag_t + INT_W'(1)) : w_mag_t;
  end

  assign o_ovf     = w_sat;
  assign o_inexact = w_sat | i_guard | i_sticky;

endmodule

// File: rtl/flt2int_rnd.sv
// Multicycle float-to-int converter: Done N+3 edges after capture, N = shift distance.
// Start is only honoured in IDLE; requests arriving while Busy are dropped, not queued.
module flt2int_rnd
  import flt2int_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int INT_W = INT_W_DEF,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [EXP_W+MAN_W:0]   FltIn,
  input  logic [1:0]             RndMode,
  output logic                   Busy,
  output logic                   Done,
  output logic [INT_W-1:0]       IntOut,
  output logic                   Ovf,
  output logic                   Inexact
);

  localparam int MAG_W = max_i(MAN_W+1, INT_W);
  localparam int CNT_W = $clog2(MAG_W+1) + 1;
  localparam int E_W   = EXP_W + 2;

  localparam logic signed [E_W-1:0] E_SATMAX = E_W'(INT_W-2);
  localparam logic signed [E_W-1:0] E_MINNEG = E_W'(INT_W-1);
  localparam logic signed [E_W-1:0] E_NEG1   = -E_W'(1);
  localparam logic signed [E_W-1:0] E_MAN    = E_W'(MAN_W);

  state_t                 r_state;
  logic [EXP_W+MAN_W:0]   r_flt;
  logic [1:0]             r_mode;
  logic [MAG_W-1:0]       r_mag;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_right, r_guard, r_sticky, r_sign, r_sat;
  logic                   r_busy, r_done, r_ovf, r_inexact;
  logic [INT_W-1:0]       r_int;

  logic                   w_sign, w_hid, w_inf, w_minneg, w_sat, w_tiny, w_right;
  logic [EXP_W-1:0]       w_exp;
  logic [MAN_W-1:0]       w_frac;
  logic [MAN_W:0]         w_sig;
  logic signed [E_W-1:0]  w_e, w_diff;
  logic [E_W-1:0]         w_nabs;
  logic [INT_W-1:0]       w_int;
  logic                   w_ovf, w_inexact;

  assign w_sign  = r_flt[EXP_W+MAN_W];
  assign w_exp   = r_flt[EXP_W+MAN_W-1:MAN_W];
  assign w_frac  = r_flt[MAN_W-1:0];
  assign w_hid   = |w_exp;
  assign w_sig   = {w_hid, w_frac};
  assign w_e     = (w_hid ? E_W'(w_exp) : E_W'(1)) - E_W'(BIAS);
  assign w_inf   = &w_exp;
  // The exact most-negative integer takes the normal left-shift path so it is not flagged.
  assign w_minneg = w_sign & (w_e == E_MINNEG) & (w_frac == '0);
  assign w_sat   = w_inf | ((w_e > E_SATMAX) & ~w_minneg);
  assign w_tiny  = w_e < E_NEG1;
  assign w_diff  = w_e - E_MAN;
  assign w_right = w_diff < 0;
  assign w_nabs  = w_right ? E_W'(-w_diff) : E_W'(w_diff);

  flt2int_round #(.INT_W(INT_W), .MAG_W(MAG_W)) u_round (
    .i_mag     (r_mag),
    .i_guard   (r_guard),
    .i_sticky  (r_sticky),
    .i_sign    (r_sign),
    .i_sat     (r_sat),
    .i_mode    (r_mode),
    .o_int     (w_int),
    .o_ovf     (w_ovf),
    .o_inexact (w_inexact)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_flt     <= '0;
      r_mode    <= '0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_right   <= 1'b0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_sign    <= 1'b0;
      r_sat     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_int     <= '0;
      r_ovf     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_flt   <= FltIn;
            r_mode  <= RndMode;
            r_busy  <= 1'b1;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_sign   <= w_sign;
          r_guard  <= 1'b0;
          r_right  <= w_right;
          r_sat    <= w_sat;
          r_cnt    <= '0;
          r_mag    <= '0;
          r_sticky <= 1'b0;
          r_state  <= S_ROUND;
          if (!w_sat) begin
            if (w_tiny) begin
              r_sticky <= |w_sig;
            end else begin
              r_mag <= MAG_W'(w_sig);
              r_cnt <= CNT_W'(w_nabs);
              if (w_nabs != '0) r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (r_right) begin
            r_mag    <= r_mag >> 1;
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end else begin
            r_mag <= r_mag << 1;
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_int     <= w_int;
          r_ovf     <= w_ovf;
          r_inexact <= w_inexact;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign IntOut  = r_int;
  assign Ovf     = r_ovf;
  assign Inexact = r_inexact;

endmodule

// File: tb/tb_flt2int_rnd.sv
// Randomized and directed bench for flt2int_rnd against an exact-arithmetic reference.
module tb_flt2int_rnd;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] FltIn;
  logic [1:0]  RndMode;
  logic        Busy, Done, Ovf, Inexact;
  logic [15:0] IntOut;

  int n_chk = 0;
  int n_bad = 0;

  flt2int_rnd dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .FltIn   (FltIn),
    .RndMode (RndMode),
    .Busy    (Busy),
    .Done    (Done),
    .IntOut  (IntOut),
    .Ovf     (Ovf),
    .Inexact (Inexact)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Value = sig * 2^(e-10), rounded on the exact remainder, then range-checked.
  function automatic void ref_model(input logic [15:0] f, input logic [1:0] m,
                                    output logic [15:0] res, output logic ovf,
                                    output logic inx, output int n);
    logic       sgn;
    int         ex, fr, e, k;
    longint     sig, q, rem, p, half, val;
    sgn = f[15];
    ex  = int'(f[14:10]);
    fr  = int'(f[9:0]);
    e   = (ex != 0) ? ex - 15 : -14;
    sig = (ex != 0) ? longint'(1024 + fr) : longint'(fr);
    if (ex == 31) n = 0;
    else if (e > 14 && !(sgn && e == 15 && fr == 0)) n = 0;
    else if (e < -1) n = 0;
    else n = (e > 10) ? e - 10 : 10 - e;
    if (ex == 31) begin
      ovf = 1'b1; inx = 1'b1;
      res = sgn ? 16'h8000 : 16'h7FFF;
      return;
    end
    k = 10 - e;
    inx = 1'b0;
    if (k > 0) begin
      p    = 64'sd1 <<< k;
      q    = sig / p;
      rem  = sig % p;
      half = p / 2;
      inx  = (rem != 0);
      if (m == 2'd1 && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
      if (m == 2'd2 && rem >= half) q = q + 1;
    end else begin
      q = sig <<< (-k);
    end
    val = sgn ? -q : q;
    if (val > 32767 || val < -32768) begin
      ovf = 1'b1; inx = 1'b1;
      res = sgn ? 16'h8000 : 16'h7FFF;
    end else begin
      ovf = 1'b0;
      res = 16'(val);
    end
  endfunction

  task automatic do_req(input logic [15:0] f, input logic [1:0] m, input string tag);
    logic [15:0] e_res;
    logic        e_ovf, e_inx;
    int          e_n, cyc;
    bit          got;
    ref_model(f, m, e_res, e_ovf, e_inx, e_n);
    @(negedge Clk);
    Start = 1'b1; FltIn = f; RndMode = m;
    @(posedge Clk); #1;
    Start = 1'b0; FltIn = 16'($urandom); RndMode = 2'($urandom);
    chk({tag, "_busy"}, 64'(Busy), 1);
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge Clk); #1;
      cyc++;
      if (Done) got = 1'b1;
    end
    chk({tag, "_lat"}, cyc, e_n + 3);
    chk({tag, "_int"}, 64'(IntOut), 64'(e_res));
    chk({tag, "_ovf"}, 64'(Ovf), 64'(e_ovf));
    chk({tag, "_inx"}, 64'(Inexact), 64'(e_inx));
    @(posedge Clk); #1;
    chk({tag, "_pulse"}, 64'(Done), 0);
    chk({tag, "_hold"}, 64'(IntOut), 64'(e_res));
  endtask

  logic [15:0] dir_f [14] = '{16'h4200, 16'h4100, 16'h4100, 16'h4100, 16'hC100,
                              16'h3A00, 16'h3400, 16'h7780, 16'h7B80, 16'hFB80,
                              16'hF800, 16'h8000, 16'h7C00, 16'hBE00};
  logic [1:0]  dir_m [14] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2,
                              2'd1, 2'd2, 2'd0, 2'd0, 2'd0,
                              2'd0, 2'd0, 2'd3, 2'd1};

  initial begin
    logic [15:0] f;
    int          cyc, ndone;
    Reset = 1'b0; Start = 1'b0; FltIn = '0; RndMode = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(Busy), 0);
    chk("rst_done", 64'(Done), 0);
    chk("rst_int", 64'(IntOut), 0);
    chk("rst_ovf", 64'(Ovf), 0);
    chk("rst_inx", 64'(Inexact), 0);
    @(negedge Clk); Reset = 1'b1;

    for (int i = 0; i < 14; i++) do_req(dir_f[i], dir_m[i], $sformatf("dir%0d", i));

    // Abort mid-shift: outputs drop asynchronously and the request never completes.
    do_req(16'h4200, 2'd0, "pre_abort");
    @(negedge Clk); Start = 1'b1; FltIn = 16'h4100; RndMode = 2'd2;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    chk("abort_busy_before", 64'(Busy), 1);
    Reset = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 0);
    chk("abort_int", 64'(IntOut), 0);
    chk("abort_done", 64'(Done), 0);
    chk("abort_ovf", 64'(Ovf), 0);
    chk("abort_inx", 64'(Inexact), 0);
    @(negedge Clk); Reset = 1'b1;
    ndone = 0;
    repeat (20) begin @(posedge Clk); #1; if (Done) ndone++; end
    chk("abort_nodone", ndone, 0);
    do_req(16'h4100, 2'd2, "post_abort");

    // Start held high through OUT must produce exactly one Done.
    @(negedge Clk); Start = 1'b1; FltIn = 16'h3400; RndMode = 2'd2;
    cyc = 0; ndone = 0;
    while (cyc < 40 && ndone == 0) begin
      @(posedge Clk); #1; cyc++;
      if (Done) ndone++;
    end
    Start = 1'b0;
    chk("hold_lat", cyc, 4);
    repeat (15) begin @(posedge Clk); #1; if (Done) ndone++; end
    chk("hold_ndone", ndone, 1);
    chk("hold_busy", 64'(Busy), 0);

    for (int i = 0; i < 200; i++) begin
      f = 16'($urandom);
      if (i % 2 == 0) f[14:10] = 5'($urandom_range(10, 20));
      do_req(f, 2'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
